// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared widths, complex word type and fixed-point helpers for the FFT butterfly.
// Contents:
//   DATA_W_DEF, FRAC_W_DEF, WORD_W_DEF - default component width, twiddle fraction bits, packed width
//   ACC_W                              - working accumulator width for rounding and saturation
//   cplx_t                             - packed complex word {re, im}
//   pack / unpack_re / unpack_im       - build or split a default-width complex word
//   sat_to                             - clip a value into a signed dw-bit range
//   round_shift                        - round-half-up arithmetic right shift
package butterfly_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 6;
    localparam int WORD_W_DEF = 2 * DATA_W_DEF;
    // Holds the widest S3 sum (2*DATA_W+2 bits), so DATA_W up to 31 is supported.
    localparam int ACC_W = 64;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic cplx_t pack(input logic signed [DATA_W_DEF-1:0] re_v, input logic signed [DATA_W_DEF-1:0] im_v);
        cplx_t c;
        c.re = re_v;
        c.im = im_v;
        return c;
    endfunction

    function automatic logic signed [DATA_W_DEF-1:0] unpack_re(input cplx_t c);
        return c.re;
    endfunction

    function automatic logic signed [DATA_W_DEF-1:0] unpack_im(input cplx_t c);
        return c.im;
    endfunction

    function automatic acc_t sat_to(input acc_t v, input int dw);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (dw - 1)) - acc_t'(1);
        lo = -hi - acc_t'(1);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Adding half an LSB before the floor shift rounds ties towards +infinity.
    function automatic acc_t round_shift(input acc_t s, input int sh);
        acc_t half;
        half = acc_t'(1) <<< (sh - 1);
        return (s + half) >>> sh;
    endfunction
endpackage

// File: rtl/butterfly_pipe_cmplx_mult.sv
// cmplx_mult: two-stage registered complex multiplier B*W (or B*conj(W)) with full-precision output.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - stall enable; all registers hold when low
//   b, w         - operands {re, im}, DATA_W bits per component
//   conj         - use conj(W) for this operand pair
//   p_re, p_im   - full-precision product, 2*DATA_W+1 bits, two cycles after capture
module cmplx_mult
    import butterfly_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    localparam int WORD_W = 2 * DATA_W,
    localparam int PW = 2 * DATA_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WORD_W-1:0]    b,
    input  logic [WORD_W-1:0]    w,
    input  logic                 conj,
    output logic signed [PW-1:0] p_re,
    output logic signed [PW-1:0] p_im
);
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_V = ~MIN_V;

    logic signed [DATA_W-1:0] w_im_in;
    logic signed [DATA_W-1:0] w_im_neg;
    logic [WORD_W-1:0]        b1;
    logic [WORD_W-1:0]        w1;
    logic signed [DATA_W-1:0] b_re;
    logic signed [DATA_W-1:0] b_im;
    logic signed [DATA_W-1:0] w_re;
    logic signed [DATA_W-1:0] w_im;

    assign w_im_in  = w[DATA_W-1:0];
    // The most negative value has no positive twin, so its negation clips to the maximum.
    assign w_im_neg = (w_im_in == MIN_V) ? MAX_V : -w_im_in;

    assign b_re = b1[WORD_W-1:DATA_W];
    assign b_im = b1[DATA_W-1:0];
    assign w_re = w1[WORD_W-1:DATA_W];
    assign w_im = w1[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b1   <= '0;
            w1   <= '0;
            p_re <= '0;
            p_im <= '0;
        end else if (en) begin
            b1   <= b;
            w1   <= {w[WORD_W-1:DATA_W], conj ? w_im_neg : w_im_in};
            p_re <= PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
            p_im <= PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        end
    end
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: three-stage radix-2 DIT butterfly X = A + B*W, Y = A - B*W with flow control.
// Ports:
//   i_CLK, i_RST          - clock, asynchronous active-high reset
//   i_valid, o_ready      - input handshake; o_ready is combinational from the output side
//   i_A, i_B, i_twiddle   - packed complex operands {re, im}
//   i_inverse, i_scale    - per-transaction conj(W) and divide-by-2 controls
//   o_valid, i_ready      - output handshake
//   o_X, o_Y              - registered, rounded and saturated results
//   o_ovf, i_clr_ovf      - sticky saturation flag and its synchronous clear
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    localparam int WORD_W = 2 * DATA_W
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WORD_W-1:0] i_A,
    input  logic [WORD_W-1:0] i_B,
    input  logic [WORD_W-1:0] i_twiddle,
    input  logic              i_inverse,
    input  logic              i_scale,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_X,
    output logic [WORD_W-1:0] o_Y,
    output logic              o_ovf,
    input  logic              i_clr_ovf
);
    localparam int PW = 2 * DATA_W + 1;

    logic                 adv;
    logic                 v1;
    logic                 v2;
    logic [WORD_W-1:0]    a1;
    logic [WORD_W-1:0]    a2;
    logic                 sc1;
    logic                 sc2;
    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;
    acc_t                 a_re_s;
    acc_t                 a_im_s;
    acc_t                 pr_s;
    acc_t                 pi_s;
    acc_t                 s_v [4];
    acc_t                 r_v [4];
    acc_t                 c_v [4];
    logic                 clip;

    // The whole pipe moves as one: it advances whenever the output slot is free or being drained.
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            o_valid <= 1'b0;
            a1      <= '0;
            a2      <= '0;
            sc1     <= 1'b0;
            sc2     <= 1'b0;
        end else if (adv) begin
            v1      <= i_valid;
            a1      <= i_A;
            sc1     <= i_scale;
            v2      <= v1;
            a2      <= a1;
            sc2     <= sc1;
            o_valid <= v2;
        end
    end

    cmplx_mult #(.DATA_W(DATA_W)) u_mult (
        .clk  (i_CLK),
        .rst  (i_RST),
        .en   (adv),
        .b    (i_B),
        .w    (i_twiddle),
        .conj (i_inverse),
        .p_re (p_re),
        .p_im (p_im)
    );

    // A is aligned to the product's binary point before the add/subtract.
    assign a_re_s = acc_t'($signed(a2[WORD_W-1:DATA_W])) <<< FRAC_W;
    assign a_im_s = acc_t'($signed(a2[DATA_W-1:0])) <<< FRAC_W;
    assign pr_s   = acc_t'(p_re);
    assign pi_s   = acc_t'(p_im);
    assign s_v[0] = a_re_s + pr_s;
    assign s_v[1] = a_im_s + pi_s;
    assign s_v[2] = a_re_s - pr_s;
    assign s_v[3] = a_im_s - pi_s;

    always_comb begin
        clip = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r_v[k] = round_shift(s_v[k], sc2 ? FRAC_W + 1 : FRAC_W);
            c_v[k] = sat_to(r_v[k], DATA_W);
            clip   = clip | (c_v[k] != r_v[k]);
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_X <= '0;
            o_Y <= '0;
        end else if (adv & v2) begin
            o_X <= {c_v[0][DATA_W-1:0], c_v[1][DATA_W-1:0]};
            o_Y <= {c_v[2][DATA_W-1:0], c_v[3][DATA_W-1:0]};
        end
    end

    // A new clip outranks a clear arriving in the same cycle.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            o_ovf <= 1'b0;
        else if (adv & v2 & clip)
            o_ovf <= 1'b1;
        else if (i_clr_ovf)
            o_ovf <= 1'b0;
    end
endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath.
- Computes X = A + B·W and Y = A − B·W on packed complex fixed-point words:
  - real part in the upper half of the word, imaginary part in the lower half;
  - both parts signed two's complement, FRAC_W fractional bits.
- Adds the following behaviour:
  - valid/ready flow control;
  - round-half-up;
  - saturation with a sticky overflow flag;
  - per-transaction inverse-FFT (conjugate twiddle) mode;
  - per-transaction divide-by-2 scaling.
- Sits between the stage address generator and the ping-pong sample RAM.

Parameters:
- DATA_W, 16: width of each real or imaginary component.
- FRAC_W, 6: fractional bits of the twiddle factor (1.0 = 2^FRAC_W). Legal range 1..DATA_W-2.
- WORD_W, 2*DATA_W: packed complex word width. Derived; do not override.

Ports:
- i_CLK, in, 1: clock. All state updates on the rising edge.
- i_RST, in, 1: reset, asynchronous, active-high.
- i_valid, in, 1: input transaction valid.
- o_ready, out, 1: block can accept an input this cycle.
- i_A, in, WORD_W: operand A {real, imag}.
- i_B, in, WORD_W: operand B {real, imag}.
- i_twiddle, in, WORD_W: twiddle W {real, imag}.
- i_inverse, in, 1: when 1, use conj(W) for this transaction.
- i_scale, in, 1: when 1, halve X and Y for this transaction.
- o_valid, out, 1: output transaction valid.
- i_ready, in, 1: downstream accepts the output.
- o_X, out, WORD_W: A + B·W, packed.
- o_Y, out, WORD_W: A − B·W, packed.
- o_ovf, out, 1: sticky saturation flag.
- i_clr_ovf, in, 1: synchronous clear of o_ovf.

Behaviour:
- Reset:
  - one clock; reset is asynchronous and active-high (i_RST).
  - While asserted: o_valid=0, o_X=0, o_Y=0, o_ovf=0, all stage-valid bits = 0.
  - Reset mid-operation discards all in-flight transactions.
- Pipeline: three stages, each with its own valid bit (v1, v2, v3; v3 drives o_valid).
  - S1: register A, B, W, inverse, scale. If inverse=1, negate W.imag here; −(−2^(DATA_W−1)) saturates to 2^(DATA_W−1)−1.
  - S2: four signed DATA_W×DATA_W products, combined to full precision (2·DATA_W+1 bits):
    - Pr = Br·Wr − Bi·Wi
    - Pi = Br·Wi + Bi·Wr
  - S3: full-precision sums, then rounding and saturation:
    - SXr = (Ar<<FRAC_W) + Pr, SYr = (Ar<<FRAC_W) − Pr; SXi and SYi likewise from Ai and Pi.
    - Shift: sh = FRAC_W + scale.
    - Rounded result: (S + 2^(sh−1)) >>> sh (arithmetic shift).
    - Saturate the result to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Latency: 3 cycles from input acceptance to o_valid when there is no backpressure. Throughput is 1 transaction per cycle.
- Flow control:
  - adv = ~o_valid | i_ready.
  - o_ready = adv, combinational.
  - Input is accepted when i_valid & o_ready.
  - All stages shift together only when adv = 1; otherwise every stage register holds.
  - Bubbles advance: an invalid stage still shifts, and its valid bit propagates as 0.
  - o_X and o_Y hold stable while o_valid & ~i_ready.
- Overflow:
  - o_ovf sets on any clipped component in a transaction that enters S3.
  - It stays set until i_clr_ovf or reset.
  - If set and clear happen in the same cycle, set wins.
- o_X and o_Y are registered. There is no combinational path from inputs to o_X/o_Y.

Decomposition:
- Package butterfly_pkg:
  - DATA_W and FRAC_W defaults;
  - packed complex word typedef;
  - pack and unpack functions for {real, imag};
  - saturate-to-DATA_W function;
  - round-shift function.
- Sub-module cmplx_mult: the S1→S2 registered complex multiplier.
  - Carries a conjugate input.
  - Stall enable = adv.
  - Full-precision output.
  - Reusable in the twiddle ROM interpolator.

Test Plan (defaults DATA_W=16, FRAC_W=6, so 1.0 = 64):
1. W=(64,0), A=(100,20), B=(30,−10), inverse=0, scale=0 → X=(130,10), Y=(70,30) exactly 3 cycles after accept; o_ovf=0.
2. W=(0,−64): same A and B → X=(90,−10), Y=(110,50). Repeat with inverse=1 → X=(110,50), Y=(90,−10).
3. Rounding: A=(0,0), B=(1,0), W=(32,0) → X=(1,0), Y=(0,0). Scaling: case 1 with scale=1 → X=(65,5), Y=(35,15).
4. Saturation: A=(32767,0), B=(100,0), W=(64,0) → X=(32767,0), Y=(32667,0), o_ovf=1.
   - o_ovf remains 1 across later clean transactions.
   - i_clr_ovf clears it the next cycle.
5. Backpressure: stream 8 transactions back-to-back, drop i_ready for 4 cycles mid-stream.
   - o_ready falls in the same cycle as i_ready.
   - No loss or duplication; outputs in order; o_X/o_Y stable while stalled.
6. Reset mid-stream: assert i_RST asynchronously with 3 transactions in flight.
   - o_valid=0, o_X=0, o_Y=0, o_ovf=0 immediately.
   - After release, the first new input emerges at latency 3.
